// File: rtl/lteq_stream_loader_pkg.sv
// lteq_pkg: shared definitions for the streaming LTEQ loader.
// Holds the loader state encoding plus the default operand/beat widths
// and the beat-count constants derived from them.
package lteq_pkg;

    typedef enum logic [1:0] {
        LOAD,
        DRAIN,
        EVAL,
        OUT
    } state_t;

    localparam int unsigned W_DEF  = 32;
    localparam int unsigned BW_DEF = 8;

    // Beats needed to carry one (A, B) operand pair.
    function automatic int unsigned beats_per_pair(input int unsigned w, input int unsigned bw);
        return (2 * w) / bw;
    endfunction

    localparam int unsigned NB    = beats_per_pair(W_DEF, BW_DEF);
    localparam int unsigned CNT_W = $clog2(NB);

endpackage

// File: rtl/lteq_stream_loader_if.sv
// lteq_stream_loader_if: input beat stream and result handshake.
//   in_valid/in_ready/in_data/in_last : operand beat stream (master -> slave)
//   out_valid/out_ready/out_lteq/out_err : result port (slave -> master)
// The loader uses the slave modport, the stream source/sink the master one.
interface lteq_stream_loader_if #(
    parameter int unsigned BW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic          out_lteq;
    logic          out_err;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_lteq, out_err
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_lteq, out_err
    );
endinterface

// File: rtl/lteq_stream_loader_core.sv
// cmp_lteq_core: purely combinational unsigned A <= B comparator.
//   a, b : W-bit unsigned operands
//   y    : 1 when a <= b
module cmp_lteq_core #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         y
);
    assign y = (a <= b);
endmodule

// File: rtl/lteq_stream_loader.sv
// lteq_stream_loader: assembles A and B from a byte stream, evaluates
// A <= B (unsigned) through cmp_lteq_core and presents a registered result.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of lteq_stream_loader_if (beat input, result output)
module lteq_stream_loader
    import lteq_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned BW = BW_DEF
) (
    input logic                  clk,
    input logic                  rst,
    lteq_stream_loader_if.slave  bus
);
    localparam int unsigned LNB   = beats_per_pair(W, BW);
    localparam int unsigned HALF  = LNB / 2;
    localparam int unsigned LCW   = $clog2(LNB);
    localparam logic [LCW-1:0] LAST_CNT = LCW'(LNB - 1);

    state_t          r_state;
    logic [LCW-1:0]  r_cnt;
    logic            r_err;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_lteq;
    logic            r_out_err;

    logic            w_accept;
    logic            w_store;
    logic            w_y;

    // Handshake outputs decode registered state only.
    assign bus.in_ready  = (r_state == LOAD) || (r_state == DRAIN);
    assign bus.out_valid = (r_state == OUT);
    assign bus.out_lteq  = r_lteq;
    assign bus.out_err   = r_out_err;

    assign w_accept = bus.in_valid && (r_state == LOAD);
    // An early last is not stored: the pair is already flagged bad.
    assign w_store  = w_accept && ((r_cnt == LAST_CNT) || !bus.in_last);

    cmp_lteq_core #(.W(W)) u_core (
        .a (r_a),
        .b (r_b),
        .y (w_y)
    );

    // Beat k lands in byte slot k: first half fills A, second half fills B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_store) begin
            for (int unsigned k = 0; k < HALF; k++) begin
                if (r_cnt == LCW'(k))        r_a[k*BW +: BW] <= bus.in_data;
                if (r_cnt == LCW'(k + HALF)) r_b[k*BW +: BW] <= bus.in_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= LOAD;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_lteq    <= 1'b0;
            r_out_err <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        if (r_cnt == LAST_CNT) begin
                            r_err   <= !bus.in_last;
                            r_state <= bus.in_last ? EVAL : DRAIN;
                        end else if (bus.in_last) begin
                            r_err   <= 1'b1;
                            r_state <= EVAL;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.in_valid && bus.in_last) r_state <= EVAL;
                end
                EVAL: begin
                    r_lteq    <= r_err ? 1'b0 : w_y;
                    r_out_err <= r_err;
                    r_state   <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_state <= LOAD;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_lteq_stream_loader.sv
// Bench for lteq_stream_loader: beat stimulus with a result scoreboard.
module tb_lteq_stream_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lteq_stream_loader_if #(.BW(8)) bus ();

    lteq_stream_loader #(.W(32), .BW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic lteq;
        logic err;
    } res_t;

    res_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic send_beat(input logic [7:0] d, input logic l);
        int t = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_accept_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'hxx;
    endtask

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b);
        logic [7:0] d;
        for (int k = 0; k < 8; k++) begin
            d = (k < 4) ? a[k*8 +: 8] : b[(k-4)*8 +: 8];
            send_beat(d, k == 7);
        end
        sb.push_back('{lteq: (a <= b), err: 1'b0});
    endtask

    task automatic wait_valid(output bit ok);
        int t = 0;
        @(negedge clk);
        while (bus.out_valid !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        ok = (bus.out_valid === 1'b1);
    endtask

    task automatic get_result(output res_t r, output bit ok);
        wait_valid(ok);
        r = '{lteq: bus.out_lteq, err: bus.out_err};
        if (ok) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.in_ready, bus.out_valid, bus.out_lteq, bus.out_err} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_state: rdy/vld/lteq/err=%b required 1000",
                     {bus.in_ready, bus.out_valid, bus.out_lteq, bus.out_err});
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        res_t r, e; bit ok;
        send_pair(32'h0000_0005, 32'h0000_0005);
        n_cmp++;
        if ({bus.out_valid, bus.in_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL eval_cycle: out_valid/in_ready=%b required 00", {bus.out_valid, bus.in_ready});
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: out_valid=%b required 1 one cycle after EVAL", bus.out_valid);
        end
        get_result(r, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || r !== e) begin
            n_fail++;
            $display("FAIL basic_5_5: got %b required %b ok=%0d", r, e, ok);
        end
    endtask

    task automatic test_back_to_back;
        res_t r, e; bit ok;
        send_pair(32'hFFFF_FFFF, 32'h0000_0000);
        wait_valid(ok);
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_before_handshake: in_ready=%b required 0", bus.in_ready);
        end
        get_result(r, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || r !== e) begin
            n_fail++;
            $display("FAIL max_vs_zero: got %b required %b ok=%0d", r, e, ok);
        end
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL handshake_edge: in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
        end
        send_pair(32'h0000_0000, 32'hFFFF_FFFF);
        get_result(r, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || r !== e) begin
            n_fail++;
            $display("FAIL zero_vs_max: got %b required %b ok=%0d", r, e, ok);
        end
    endtask

    task automatic test_hold;
        res_t r, e, first; bit ok;
        send_pair(32'h8000_0000, 32'h7FFF_FFFF);
        wait_valid(ok);
        first = '{lteq: bus.out_lteq, err: bus.out_err};
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_lteq !== first.lteq || bus.out_err !== first.err) begin
                n_fail++;
                $display("FAIL hold_stable cycle %0d: vld=%b rdy=%b res=%b required vld=1 rdy=0 res=%b",
                         c, bus.out_valid, bus.in_ready, {bus.out_lteq, bus.out_err}, first);
            end
            @(negedge clk);
        end
        get_result(r, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || r !== e) begin
            n_fail++;
            $display("FAIL unsigned_msb: got %b required %b ok=%0d", r, e, ok);
        end
    endtask

    task automatic test_early_last;
        res_t r, e; bit ok;
        for (int k = 0; k < 4; k++) send_beat(8'h11 * k[7:0], k == 3);
        sb.push_back('{lteq: 1'b0, err: 1'b1});
        get_result(r, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || r !== e) begin
            n_fail++;
            $display("FAIL early_last: got %b required %b ok=%0d", r, e, ok);
        end
        send_pair(32'd1, 32'd2);
        get_result(r, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || r !== e) begin
            n_fail++;
            $display("FAIL after_early_last: got %b required %b ok=%0d", r, e, ok);
        end
    endtask

    task automatic test_missing_last;
        res_t r, e; bit ok;
        for (int k = 0; k < 8; k++) send_beat(8'h00, 1'b0);
        send_beat(8'hAA, 1'b0);
        send_beat(8'h55, 1'b1);
        sb.push_back('{lteq: 1'b0, err: 1'b1});
        get_result(r, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || r !== e) begin
            n_fail++;
            $display("FAIL missing_last: got %b required %b ok=%0d", r, e, ok);
        end
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_result: out_valid=%b required 0", bus.out_valid);
        end
        send_pair(32'd7, 32'd9);
        get_result(r, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || r !== e) begin
            n_fail++;
            $display("FAIL after_missing_last: got %b required %b ok=%0d", r, e, ok);
        end
    endtask

    task automatic test_reset_mid;
        res_t r, e; bit ok;
        for (int k = 0; k < 5; k++) send_beat(8'hC3, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_mid_load: in_ready/out_valid=%b required 10", {bus.in_ready, bus.out_valid});
        end
        @(negedge clk); rst = 1'b0;
        send_pair(32'd3, 32'd2);
        get_result(r, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || r !== e) begin
            n_fail++;
            $display("FAIL after_reset_load: got %b required %b ok=%0d", r, e, ok);
        end
        // Reset during OUT: the pending result is dropped from the scoreboard.
        send_pair(32'd10, 32'd20);
        wait_valid(ok);
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        n_cmp++;
        if ({bus.out_valid, bus.out_lteq, bus.out_err, bus.in_ready} !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_mid_out: vld/lteq/err/rdy=%b required 0001",
                     {bus.out_valid, bus.out_lteq, bus.out_err, bus.in_ready});
        end
        @(negedge clk); rst = 1'b0;
        send_pair(32'h0000_0100, 32'h0000_00FF);
        get_result(r, ok);
        e = sb.pop_front();
        n_cmp++;
        if (!ok || r !== e) begin
            n_fail++;
            $display("FAIL after_reset_out: got %b required %b ok=%0d", r, e, ok);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_hold;
        test_early_last;
        test_missing_last;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
